// File: rtl/operand_fetch_if.sv
// Decode->fetch and fetch->execute handshake bundle for the operand-fetch stage.
// The master side feeds instructions in and drains operands out.
// The slave side is the operand-fetch stage itself.
interface operand_fetch_if #(
    parameter int PAYLOAD_W = 64
);
    // Upstream (decode) channel
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic [PAYLOAD_W-1:0] in_payload;

    // Downstream (execute) channel
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_op1;
    logic [31:0]          out_op2;
    logic [PAYLOAD_W-1:0] out_payload;

    modport master (
        output in_valid,
        output in_rs1,
        output in_rs2,
        output in_payload,
        input  in_ready,
        input  out_valid,
        input  out_op1,
        input  out_op2,
        input  out_payload,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_rs1,
        input  in_rs2,
        input  in_payload,
        output in_ready,
        output out_valid,
        output out_op1,
        output out_op2,
        output out_payload,
        input  out_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: two-deep pipeline (R = read pending, O = output register).
// Drives register-file read addresses, captures the synchronous read data one
// cycle later and bypasses writeback data so the operands handed to execute
// are always architecturally current. One instruction per cycle throughput.
module operand_fetch #(
    parameter int PAYLOAD_W = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    operand_fetch_if.slave bus,
    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data
);
    localparam int NOPS = 2;

    // ------------------------------------------------------------------
    // Shared pipeline control
    // ------------------------------------------------------------------
    logic                 r_valid_q, r_valid_d;
    logic [PAYLOAD_W-1:0] r_payload_q, r_payload_d;
    logic                 out_valid_q, out_valid_d;
    logic [PAYLOAD_W-1:0] o_payload_q, o_payload_d;

    logic advance;   // R moves into O at the coming edge
    logic in_ready;  // R can take a new instruction at the coming edge
    logic accept;    // a new instruction is loaded into R
    logic r_hold;    // R keeps its instruction at the coming edge
    logic o_hold;    // O is presenting and execute is stalling it

    assign advance  = r_valid_q && (!out_valid_q || bus.out_ready);
    assign in_ready = !r_valid_q || advance;
    assign accept   = bus.in_valid && in_ready;
    assign r_hold   = r_valid_q && !advance;
    assign o_hold   = out_valid_q && !bus.out_ready;

    assign bus.in_ready = in_ready;

    // ------------------------------------------------------------------
    // Per-operand views so both operands share one datapath description
    // ------------------------------------------------------------------
    logic [4:0]  in_rs    [NOPS];
    logic [31:0] rf_rdata [NOPS];
    logic [4:0]  rf_addr  [NOPS];
    logic [31:0] o_op     [NOPS];

    assign in_rs[0]    = bus.in_rs1;
    assign in_rs[1]    = bus.in_rs2;
    assign rf_rdata[0] = rf_rdata1;
    assign rf_rdata[1] = rf_rdata2;

    genvar gi;
    for (gi = 0; gi < NOPS; gi++) begin : g_opnd
        logic [4:0]  r_rs_q,  r_rs_d;
        logic        r_hit_q, r_hit_d;
        logic [31:0] r_sav_q, r_sav_d;
        logic [4:0]  o_rs_q,  o_rs_d;
        logic [31:0] o_op_q,  o_op_d;

        logic        cap_hit;  // writeback lands on the address being read this edge
        logic        r_live;   // live writeback targets R's register
        logic        o_live;   // live writeback targets O's register
        logic [31:0] r_val;    // resolved R operand without the live override

        // When R can accept, read the incoming index; otherwise keep re-reading
        // R's own index so the read data stays fresh while stalled.
        assign rf_addr[gi] = in_ready ? in_rs[gi] : r_rs_q;

        // The register file returns the pre-write value when read and write
        // share an edge, so remember the written value alongside the read.
        assign cap_hit = wb_en && (wb_addr == rf_addr[gi]) && (rf_addr[gi] != 5'd0);
        assign r_live  = wb_en && (wb_addr == r_rs_q) && (r_rs_q != 5'd0);
        assign o_live  = wb_en && (wb_addr == o_rs_q) && (o_rs_q != 5'd0);

        // x0 reads zero; otherwise the saved bypass wins over the stale read data.
        assign r_val = (r_rs_q == 5'd0) ? 32'd0 :
                       r_hit_q          ? r_sav_q : rf_rdata[gi];

        // Next-state for this operand's R and O slices.
        always_comb begin
            r_rs_d  = r_rs_q;
            r_hit_d = r_hit_q;
            r_sav_d = r_sav_q;
            o_rs_d  = o_rs_q;
            o_op_d  = o_op_q;

            if (accept) begin
                r_rs_d = in_rs[gi];
            end
            if (accept || r_hold) begin
                r_hit_d = cap_hit;
                r_sav_d = wb_data;
            end

            if (advance) begin
                o_rs_d = r_rs_q;
                o_op_d = r_live ? wb_data : r_val;
            end else if (o_hold && o_live) begin
                o_op_d = wb_data;
            end
        end

        // Operand state registers.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_rs_q  <= 5'd0;
                r_hit_q <= 1'b0;
                r_sav_q <= 32'd0;
                o_rs_q  <= 5'd0;
                o_op_q  <= 32'd0;
            end else begin
                r_rs_q  <= r_rs_d;
                r_hit_q <= r_hit_d;
                r_sav_q <= r_sav_d;
                o_rs_q  <= o_rs_d;
                o_op_q  <= o_op_d;
            end
        end

        assign o_op[gi] = o_op_q;
    end

    assign rf_rs1 = rf_addr[0];
    assign rf_rs2 = rf_addr[1];

    // Next-state for the valid bits and the pass-through payload.
    always_comb begin
        r_valid_d   = r_valid_q;
        r_payload_d = r_payload_q;
        out_valid_d = out_valid_q;
        o_payload_d = o_payload_q;

        if (accept) begin
            r_valid_d   = 1'b1;
            r_payload_d = bus.in_payload;
        end else if (advance) begin
            r_valid_d   = 1'b0;
        end

        if (advance) begin
            out_valid_d = 1'b1;
            o_payload_d = r_payload_q;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and payload registers; reset drops anything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid_q   <= 1'b0;
            r_payload_q <= '0;
            out_valid_q <= 1'b0;
            o_payload_q <= '0;
        end else begin
            r_valid_q   <= r_valid_d;
            r_payload_q <= r_payload_d;
            out_valid_q <= out_valid_d;
            o_payload_q <= o_payload_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_op1     = o_op[0];
    assign bus.out_op2     = o_op[1];
    assign bus.out_payload = o_payload_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a scoreboard queue and an
// independent output monitor. A simple register-file model provides the
// one-cycle read latency with old-data-on-collision behaviour.
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rdata1 = 32'd0;
    logic [31:0] rf_rdata2 = 32'd0;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    operand_fetch_if #(.PAYLOAD_W(64)) ifc ();

    operand_fetch #(.PAYLOAD_W(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (ifc),
        .rf_rs1    (rf_rs1),
        .rf_rs2    (rf_rs2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    // Register file model: synchronous read, no write-through, x0 stored naively.
    logic [31:0] rf_mem [32] = '{default: 32'd0};
    always @(posedge clk) begin
        rf_rdata1 <= rf_mem[rf_rs1];
        rf_rdata2 <= rf_mem[rf_rs2];
        if (wb_en) rf_mem[wb_addr] <= wb_data;
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [63:0] pay;
    } exp_t;

    exp_t sb_q [$];
    int   fire_log [$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    exp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] o1, input logic [31:0] o2, input logic [63:0] p);
        exp_t e;
        e.op1 = o1;
        e.op2 = o2;
        e.pay = p;
        sb_q.push_back(e);
    endtask

    // Present an instruction and return just after the edge that accepts it.
    task automatic send(input logic [4:0] a, input logic [4:0] b, input logic [63:0] p);
        bit ok;
        ok = 1'b0;
        ifc.in_rs1     = a;
        ifc.in_rs2     = b;
        ifc.in_payload = p;
        ifc.in_valid   = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (ifc.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept payload=%h", p);
        end
    endtask

    task automatic wbw(input logic [4:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        cyc();
        wb_en   = 1'b0;
    endtask

    // Monitor: every fire on the output channel consumes one scoreboard entry.
    always @(negedge clk) begin
        if (reset_n && ifc.out_valid && ifc.out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=payload_%h required=no_output", ifc.out_payload);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_op1", {32'd0, ifc.out_op1}, {32'd0, mon_e.op1});
                chk("out_op2", {32'd0, ifc.out_op2}, {32'd0, mon_e.op2});
                chk("out_payload", ifc.out_payload, mon_e.pay);
                $display("txn %0d cycle %0d op1=%h op2=%h payload=%h",
                         n_out, cyc_cnt, ifc.out_op1, ifc.out_op2, ifc.out_payload);
            end
            fire_log.push_back(cyc_cnt);
            n_out++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n        = 1'b0;
        ifc.in_valid   = 1'b0;
        ifc.in_rs1     = 5'd0;
        ifc.in_rs2     = 5'd0;
        ifc.in_payload = 64'd0;
        ifc.out_ready  = 1'b0;
        wb_en          = 1'b0;
        wb_addr        = 5'd0;
        wb_data        = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc();
        chk("rst_in_ready", {63'd0, ifc.in_ready}, 64'd1);

        // Fill O and R, then pull reset mid-cycle: everything must vanish.
        send(5'd1, 5'd2, 64'h1);
        send(5'd3, 5'd4, 64'h2);
        ifc.in_valid = 1'b0;
        chk("inflight_valid", {63'd0, ifc.out_valid}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
        chk("rst_out_op1", {32'd0, ifc.out_op1}, 64'd0);
        chk("rst_out_op2", {32'd0, ifc.out_op2}, 64'd0);
        chk("rst_out_payload", ifc.out_payload, 64'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        cyc();
        chk("post_rst_valid", {63'd0, ifc.out_valid}, 64'd0);
        chk("post_rst_in_ready", {63'd0, ifc.in_ready}, 64'd1);

        // Preload the register file through writeback.
        wbw(5'd1, 32'h101);
        wbw(5'd2, 32'h202);
        wbw(5'd3, 32'h303);
        wbw(5'd4, 32'h404);
        wbw(5'd5, 32'h11);
        wbw(5'd6, 32'h22);
        ifc.out_ready = 1'b1;

        // Plain read with one-cycle latency.
        push(32'h11, 32'h22, 64'hA);
        send(5'd5, 5'd6, 64'hA);
        ifc.in_valid = 1'b0;
        chk("lat_not_yet", {63'd0, ifc.out_valid}, 64'd0);
        cyc();
        chk("lat_valid", {63'd0, ifc.out_valid}, 64'd1);
        chk("lat_op1", {32'd0, ifc.out_op1}, 64'h11);
        cyc();

        // Write on the accept edge: register file returns old data, saved bypass must win.
        wb_en   = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'hDEAD;
        push(32'hDEAD, 32'd0, 64'hB);
        send(5'd7, 5'd0, 64'hB);
        wb_en        = 1'b0;
        ifc.in_valid = 1'b0;
        cyc();
        cyc();

        // Write while the instruction sits in R: live writeback wins on advance.
        push(32'hBEEF, 32'h11, 64'hC);
        send(5'd8, 5'd5, 64'hC);
        ifc.in_valid = 1'b0;
        wb_en   = 1'b1;
        wb_addr = 5'd8;
        wb_data = 32'hBEEF;
        cyc();
        wb_en = 1'b0;
        cyc();

        // Backpressure: O held, R full, writeback to x5 must reach both.
        ifc.out_ready = 1'b0;
        push(32'h99, 32'h22, 64'hD);
        push(32'h99, 32'hDEAD, 64'hE);
        send(5'd5, 5'd6, 64'hD);
        send(5'd5, 5'd7, 64'hE);
        ifc.in_valid = 1'b0;
        chk("hold_in_ready", {63'd0, ifc.in_ready}, 64'd0);
        chk("hold_valid", {63'd0, ifc.out_valid}, 64'd1);
        chk("hold_op1_before", {32'd0, ifc.out_op1}, 64'h11);
        wbw(5'd5, 32'h99);
        chk("hold_op1_updated", {32'd0, ifc.out_op1}, 64'h99);
        chk("hold_op2_kept", {32'd0, ifc.out_op2}, 64'h22);
        chk("hold_in_ready2", {63'd0, ifc.in_ready}, 64'd0);
        cyc();
        cyc();
        ifc.out_ready = 1'b1;
        cyc();
        cyc();
        cyc();

        // x0 never bypasses, even with a writeback addressed to it.
        wb_en   = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'hFFFF;
        push(32'd0, 32'd0, 64'hF);
        send(5'd0, 5'd0, 64'hF);
        ifc.in_valid = 1'b0;
        cyc();
        wb_en = 1'b0;
        cyc();

        // Back-to-back stream; x0 now holds 0xFFFF in the model but must read 0.
        push(32'h101, 32'h202, 64'h10);
        push(32'h303, 32'h404, 64'h11);
        push(32'h99, 32'h22, 64'h12);
        push(32'd0, 32'hDEAD, 64'h13);
        send(5'd1, 5'd2, 64'h10);
        send(5'd3, 5'd4, 64'h11);
        send(5'd5, 5'd6, 64'h12);
        send(5'd0, 5'd7, 64'h13);
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) cyc();
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        n = fire_log.size();
        if (n >= 4) begin
            for (int k = 1; k <= 3; k++)
                chk("stream_gap", 64'(fire_log[n-k] - fire_log[n-k-1]), 64'd1);
        end else begin
            checks++;
            errors++;
            $display("FAIL stream_count actual=%0d required=4_or_more", n);
        end
        chk("outputs_total", 64'(n_out), 64'd10);
        cyc();
        chk("final_valid", {63'd0, ifc.out_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
